// File: rtl/blk_copy_dma_pkg.sv
// rtl/blk_copy_dma_pkg.sv - shared encodings and helpers for the block copy DMA
package blk_copy_dma_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_RD    = 3'd2;
  localparam logic [2:0] ST_WR    = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Byte stride of one element; the illegal size yields 0 and never reaches memory.
  function automatic logic [2:0] size_step(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/blk_copy_addr_gen.sv
// rtl/blk_copy_addr_gen.sv - source/destination pointers with overlap-safe direction choice
module blk_copy_addr_gen
  import blk_copy_dma_pkg::*;
#(
  parameter int LEN_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              setup,
  input  logic              advance,
  input  logic [0:ADDR_W-1] src_addr,
  input  logic [0:ADDR_W-1] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [1:0]        size,
  output logic [0:ADDR_W-1] src_ptr,
  output logic [0:ADDR_W-1] dst_ptr
);

  logic              descending;
  logic              overlap;
  logic [0:ADDR_W-1] step;
  logic [0:ADDR_W-1] span;
  logic [0:ADDR_W-1] last_off;

  assign step     = ADDR_W'(size_step(size));
  assign span     = ADDR_W'(length) * step;
  assign last_off = span - step;
  // A destination starting inside the source would clobber unread data going upward.
  assign overlap  = (dst_ptr > src_ptr) && (dst_ptr < src_ptr + span);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      src_ptr    <= '0;
      dst_ptr    <= '0;
      descending <= 1'b0;
    end else if (load) begin
      src_ptr    <= src_addr;
      dst_ptr    <= dst_addr;
      descending <= 1'b0;
    end else if (setup) begin
      descending <= overlap;
      if (overlap) begin
        src_ptr <= src_ptr + last_off;
        dst_ptr <= dst_ptr + last_off;
      end
    end else if (advance) begin
      if (descending) begin
        src_ptr <= src_ptr - step;
        dst_ptr <= dst_ptr - step;
      end else begin
        src_ptr <= src_ptr + step;
        dst_ptr <= dst_ptr + step;
      end
    end
  end

endmodule

// File: rtl/blk_copy_dma.sv
// rtl/blk_copy_dma.sv - block copy initiator sharing the data memory port with the CPU
module blk_copy_dma
  import blk_copy_dma_pkg::*;
#(
  parameter int LEN_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [0:ADDR_W-1] src_addr,
  input  logic [0:ADDR_W-1] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [1:0]        size,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              aborted,
  output logic [LEN_W-1:0]  count,
  output logic [0:ADDR_W-1] mem_addr,
  output logic [0:31]       mem_wdata,
  output logic              mem_we,
  output logic              mem_byte,
  output logic              mem_half_word,
  output logic              mem_sign_extend,
  input  logic [0:31]       mem_rdata
);

  logic [2:0]        state;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  count_nxt;
  logic [1:0]        size_r;
  logic [0:31]       wdata_r;
  logic [0:ADDR_W-1] src_ptr;
  logic [0:ADDR_W-1] dst_ptr;
  logic              access;

  blk_copy_addr_gen #(
    .LEN_W  (LEN_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     ((state == ST_IDLE) && start),
    .setup    (state == ST_SETUP),
    .advance  (state == ST_WR),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (len_r),
    .size     (size_r),
    .src_ptr  (src_ptr),
    .dst_ptr  (dst_ptr)
  );

  assign count_nxt = count + LEN_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      len_r   <= '0;
      size_r  <= SZ_BYTE;
      count   <= '0;
      err     <= 1'b0;
      aborted <= 1'b0;
      wdata_r <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_r   <= length;
            size_r  <= size;
            count   <= '0;
            err     <= 1'b0;
            aborted <= 1'b0;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (size_r == SZ_ILLEGAL) begin
            err   <= 1'b1;
            state <= ST_DONE;
          end else if (abort) begin
            aborted <= 1'b1;
            state   <= ST_DONE;
          end else if (len_r == '0) begin
            state <= ST_DONE;
          end else begin
            state <= ST_RD;
          end
        end
        ST_RD: begin
          wdata_r <= mem_rdata;
          if (abort) begin
            aborted <= 1'b1;
            state   <= ST_DONE;
          end else begin
            state <= ST_WR;
          end
        end
        ST_WR: begin
          // The write issued this cycle has landed, so it counts even when aborting.
          if (count != len_r) count <= count_nxt;
          if (count_nxt == len_r) begin
            state <= ST_DONE;
          end else if (abort) begin
            aborted <= 1'b1;
            state   <= ST_DONE;
          end else begin
            state <= ST_RD;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign access          = (state == ST_RD) || (state == ST_WR);
  assign busy            = (state != ST_IDLE);
  assign done            = (state == ST_DONE);
  assign mem_we          = (state == ST_WR);
  assign mem_byte        = access && (size_r == SZ_BYTE);
  assign mem_half_word   = access && (size_r == SZ_HALF);
  assign mem_sign_extend = 1'b0;
  assign mem_wdata       = wdata_r;
  assign mem_addr        = (state == ST_RD) ? src_ptr :
                           (state == ST_WR) ? dst_ptr : '0;

endmodule

// File: tb/tb_blk_copy_dma.sv
// tb/tb_blk_copy_dma.sv - self-checking bench for blk_copy_dma with a byte memory model
module tb_blk_copy_dma;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [0:31] src_addr = '0;
  logic [0:31] dst_addr = '0;
  logic [15:0] length = '0;
  logic [1:0]  size = '0;
  logic        busy, done, err, aborted;
  logic [15:0] count;
  logic [0:31] mem_addr, mem_wdata;
  logic [0:31] mem_rdata = '0;
  logic        mem_we, mem_byte, mem_half_word, mem_sign_extend;

  logic [7:0]  mem     [0:4095];
  logic [7:0]  exp_mem [0:4095];
  bit [31:0]   wr_addr_q[$];
  bit [31:0]   wr_data_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_pulses = 0;
  bit          sext_seen = 1'b0;

  always #5 clock = ~clock;

  blk_copy_dma #(.LEN_W(16), .ADDR_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .length(length), .size(size), .abort(abort),
    .busy(busy), .done(done), .err(err), .aborted(aborted), .count(count),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_byte(mem_byte), .mem_half_word(mem_half_word),
    .mem_sign_extend(mem_sign_extend), .mem_rdata(mem_rdata)
  );

  // Big-endian byte memory: byte/half data sits in the low-order bits of the bus.
  function automatic logic [31:0] mem_read(bit [31:0] a, bit b, bit h);
    bit [11:0] i;
    i = a[11:0];
    if (b) return {24'h0, mem[i]};
    if (h) return {16'h0, mem[i], mem[i + 12'd1]};
    return {mem[i], mem[i + 12'd1], mem[i + 12'd2], mem[i + 12'd3]};
  endfunction

  task automatic set_word(input bit [31:0] a, input bit [31:0] w);
    for (int k = 0; k < 4; k++) mem[a[11:0] + 12'(k)] = w[31-8*k -: 8];
  endtask

  always @(negedge clock) begin : mem_model
    bit [31:0] a;
    bit [31:0] wd;
    a  = mem_addr;
    wd = mem_wdata;
    if (mem_sign_extend === 1'b1) sext_seen = 1'b1;
    if (done === 1'b1) done_pulses++;
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(a);
      wr_data_q.push_back(wd);
      if (mem_byte) mem[a[11:0]] = wd[7:0];
      else if (mem_half_word) begin
        mem[a[11:0]]         = wd[15:8];
        mem[a[11:0] + 12'd1] = wd[7:0];
      end else begin
        for (int k = 0; k < 4; k++) mem[a[11:0] + 12'(k)] = wd[31-8*k -: 8];
      end
    end else begin
      mem_rdata <= mem_read(a, mem_byte, mem_half_word);
    end
  end

  // Called #1 after a rising edge; returns the cycle (start cycle = 0) in which done was seen.
  task automatic run_copy(input bit [31:0] s, input bit [31:0] d, input bit [15:0] l,
                          input bit [1:0] z, input int abort_at, input int restart_at,
                          output int cyc);
    wr_addr_q.delete();
    wr_data_q.delete();
    src_addr = s; dst_addr = d; length = l; size = z; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      abort = (cyc == abort_at);
      start = (cyc == restart_at);
      if (start) length = 16'd1;
      @(posedge clock); #1;
      cyc++;
    end
    abort = 1'b0;
    start = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    #12;
    n_cmp++; if ({busy, done, err, aborted, mem_we, mem_byte, mem_half_word} !== 7'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000000", {busy, done, err, aborted, mem_we, mem_byte, mem_half_word}); end
    n_cmp++; if (count !== 16'h0) begin n_bad++; $display("FAIL reset_count: got %0h want 0", count); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %0h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %0h want 0", mem_wdata); end
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_word_copy;
    int cyc;
    bit [31:0] src_w [4];
    src_w = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
    for (int i = 0; i < 4; i++) set_word(32'h100 + 32'(4*i), src_w[i]);
    run_copy(32'h100, 32'h200, 16'd4, 2'b10, -1, -1, cyc);
    n_cmp++; if (cyc !== 10) begin n_bad++; $display("FAIL word_done_cycle: got %0d want 10", cyc); end
    n_cmp++; if (count !== 16'd4) begin n_bad++; $display("FAIL word_count: got %0d want 4", count); end
    n_cmp++; if ({err, aborted} !== 2'b00) begin n_bad++; $display("FAIL word_err_abort: got %b want 00", {err, aborted}); end
    n_cmp++; if (wr_addr_q.size() !== 4) begin n_bad++; $display("FAIL word_nwrites: got %0d want 4", wr_addr_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mem_read(32'h200 + 32'(4*i), 1'b0, 1'b0) !== src_w[i]) begin
        n_bad++; $display("FAIL word_data[%0d]: got %0h want %0h", i, mem_read(32'h200 + 32'(4*i), 1'b0, 1'b0), src_w[i]); end
    end
    n_cmp++; if ({done, busy} !== 2'b00) begin n_bad++; $display("FAIL word_done_width: got %b want 00", {done, busy}); end
  endtask

  task automatic test_overlap_byte;
    int cyc;
    for (int i = 0; i < 4; i++) mem[12'h10 + 12'(i)] = 8'(i + 1);
    run_copy(32'h10, 32'h12, 16'd4, 2'b00, -1, -1, cyc);
    n_cmp++; if (cyc !== 10) begin n_bad++; $display("FAIL ovl_done_cycle: got %0d want 10", cyc); end
    n_cmp++; if (wr_addr_q.size() == 0 || wr_addr_q[0] !== 32'h15) begin
      n_bad++; $display("FAIL ovl_first_addr: got %0h want 15", (wr_addr_q.size() == 0) ? 32'hFFFFFFFF : wr_addr_q[0]); end
    n_cmp++; if ({mem[12'h12], mem[12'h13], mem[12'h14], mem[12'h15]} !== 32'h01020304) begin
      n_bad++; $display("FAIL ovl_dst: got %0h want 01020304", {mem[12'h12], mem[12'h13], mem[12'h14], mem[12'h15]}); end
    n_cmp++; if ({mem[12'h10], mem[12'h11]} !== 16'h0102) begin
      n_bad++; $display("FAIL ovl_src_kept: got %0h want 0102", {mem[12'h10], mem[12'h11]}); end
  endtask

  task automatic test_half_zext;
    int cyc;
    mem[12'h300] = 8'h80; mem[12'h301] = 8'h01;
    sext_seen = 1'b0;
    run_copy(32'h300, 32'h340, 16'd1, 2'b01, -1, -1, cyc);
    n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL half_done_cycle: got %0d want 4", cyc); end
    n_cmp++; if (sext_seen !== 1'b0) begin n_bad++; $display("FAIL half_sext: got %b want 0", sext_seen); end
    n_cmp++; if (wr_data_q.size() !== 1 || wr_data_q[0] !== 32'h00008001) begin
      n_bad++; $display("FAIL half_wdata: got %0h (n=%0d) want 00008001", (wr_data_q.size() == 0) ? 32'hFFFFFFFF : wr_data_q[0], wr_data_q.size()); end
    n_cmp++; if ({mem[12'h340], mem[12'h341]} !== 16'h8001) begin
      n_bad++; $display("FAIL half_dst: got %0h want 8001", {mem[12'h340], mem[12'h341]}); end
  endtask

  task automatic test_degenerate;
    int cyc;
    run_copy(32'h100, 32'h800, 16'd0, 2'b10, -1, -1, cyc);
    n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL len0_done_cycle: got %0d want 2", cyc); end
    n_cmp++; if (wr_addr_q.size() !== 0) begin n_bad++; $display("FAIL len0_writes: got %0d want 0", wr_addr_q.size()); end
    run_copy(32'h100, 32'h800, 16'd5, 2'b11, -1, -1, cyc);
    n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL ill_done_cycle: got %0d want 2", cyc); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ill_err: got %b want 1", err); end
    n_cmp++; if (wr_addr_q.size() !== 0) begin n_bad++; $display("FAIL ill_writes: got %0d want 0", wr_addr_q.size()); end
  endtask

  task automatic test_abort_restart;
    int cyc;
    run_copy(32'h500, 32'h600, 16'd8, 2'b10, 6, 3, cyc);
    n_cmp++; if (cyc !== 7) begin n_bad++; $display("FAIL abort_done_cycle: got %0d want 7", cyc); end
    n_cmp++; if (count !== 16'd2) begin n_bad++; $display("FAIL abort_count: got %0d want 2", count); end
    n_cmp++; if ({aborted, err} !== 2'b10) begin n_bad++; $display("FAIL abort_flag: got %b want 10", {aborted, err}); end
    n_cmp++; if (wr_addr_q.size() !== 2) begin n_bad++; $display("FAIL abort_writes: got %0d want 2", wr_addr_q.size()); end
    run_copy(32'h500, 32'h600, 16'd2, 2'b10, -1, -1, cyc);
    n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL restart_done_cycle: got %0d want 6", cyc); end
    n_cmp++; if ({aborted, count} !== {1'b0, 16'd2}) begin
      n_bad++; $display("FAIL restart_state: got aborted=%b count=%0d want 0/2", aborted, count); end
  endtask

  task automatic test_reset_mid;
    int k, pulses, cyc;
    src_addr = 32'h700; dst_addr = 32'h780; length = 16'd4; size = 2'b10; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    k = 0;
    while (mem_we !== 1'b1 && k < 20) begin @(posedge clock); #1; k++; end
    n_cmp++; if (k >= 20) begin n_bad++; $display("FAIL rst_reach_wr: got timeout want mem_we"); end
    pulses = done_pulses;
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({mem_we, busy} !== 2'b00) begin n_bad++; $display("FAIL rst_async: got %b want 00", {mem_we, busy}); end
    repeat (3) @(negedge clock);
    n_cmp++; if (done_pulses !== pulses) begin n_bad++; $display("FAIL rst_no_done: got %0d want %0d", done_pulses, pulses); end
    reset_n = 1'b1;
    @(posedge clock); #1;
    set_word(32'h700, 32'hCAFEF00D);
    run_copy(32'h700, 32'h7C0, 16'd1, 2'b10, -1, -1, cyc);
    n_cmp++; if (cyc !== 4 || count !== 16'd1) begin n_bad++; $display("FAIL rst_recover: got cyc=%0d count=%0d want 4/1", cyc, count); end
    n_cmp++; if (mem_read(32'h7C0, 1'b0, 1'b0) !== 32'hCAFEF00D) begin
      n_bad++; $display("FAIL rst_recover_data: got %0h want cafef00d", mem_read(32'h7C0, 1'b0, 1'b0)); end
  endtask

  // Reference: memmove semantics on a byte image, plus the ordering rule for the first write.
  task automatic test_random;
    int cyc, step, l, off, nb, bad_bytes, first_bad;
    bit [1:0] z;
    bit [31:0] s, d, first_addr;
    logic [7:0] tmp [0:23];
    for (int it = 0; it < 10; it++) begin
      z    = 2'($urandom_range(0, 2));
      step = 1 << z;
      l    = $urandom_range(1, 6);
      nb   = l * step;
      s    = 32'h400 + 32'($urandom_range(0, 255) * step);
      if ($urandom_range(0, 1) == 1) begin
        off = int'($urandom_range(0, 16)) - 8;
        d   = s + 32'(off * step);
      end else begin
        d = 32'h900 + 32'($urandom_range(0, 255) * step);
      end
      for (int i = 0; i < 4096; i++) exp_mem[i] = mem[i];
      for (int i = 0; i < nb; i++) tmp[i] = exp_mem[12'(s + 32'(i))];
      for (int i = 0; i < nb; i++) exp_mem[12'(d + 32'(i))] = tmp[i];
      first_addr = ((d > s) && (d < s + 32'(nb))) ? d + 32'(nb - step) : d;
      run_copy(s, d, 16'(l), z, -1, -1, cyc);
      n_cmp++; if (cyc !== 2 + 2*l) begin n_bad++; $display("FAIL rnd%0d_done_cycle: got %0d want %0d", it, cyc, 2 + 2*l); end
      n_cmp++; if (count !== 16'(l)) begin n_bad++; $display("FAIL rnd%0d_count: got %0d want %0d", it, count, l); end
      n_cmp++; if (wr_addr_q.size() == 0 || wr_addr_q[0] !== first_addr) begin
        n_bad++; $display("FAIL rnd%0d_first_addr: got %0h want %0h", it, (wr_addr_q.size() == 0) ? 32'hFFFFFFFF : wr_addr_q[0], first_addr); end
      bad_bytes = 0; first_bad = -1;
      for (int i = 0; i < 4096; i++) if (mem[i] !== exp_mem[i]) begin
        bad_bytes++; if (first_bad < 0) first_bad = i; end
      n_cmp++; if (bad_bytes !== 0) begin
        n_bad++; $display("FAIL rnd%0d_image: got %0d bad bytes (first %0h) want 0 (s=%0h d=%0h l=%0d z=%0d)", it, bad_bytes, first_bad, s, d, l, z); end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    test_reset;
    test_word_copy;
    test_overlap_byte;
    test_half_zext;
    test_degenerate;
    test_abort_restart;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
